// File: rtl/vga_mem_pkg.sv
// Shared types and defaults for the frame/spectrum memory arbiter.
// Holds the sequencer state enum and the default bus widths and clear word.
package vga_mem_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    localparam int          DEF_ADDR_W      = 16;
    localparam int          DEF_DATA_W      = 32;
    localparam logic [31:0] DEF_CLEAR_VALUE = 32'h0000_0000;

endpackage

// File: rtl/vga_mem_arbiter.sv
// Arbiter for the single-port frame memory: VGA reads, FFT writes and a clear sweep.
// Grants are combinational; read data returns one cycle after a read grant.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                DEPTH       = 65536,
    parameter int                MAX_RD_RUN  = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(DEF_CLEAR_VALUE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rd_read,
    input  logic [ADDR_W-1:0]   rd_address,
    output logic                rd_waitrequest,
    output logic [DATA_W-1:0]   rd_readdata,
    output logic                rd_readdatavalid,
    input  logic                wr_write,
    input  logic [ADDR_W-1:0]   wr_address,
    input  logic [DATA_W-1:0]   wr_writedata,
    input  logic [DATA_W/8-1:0] wr_byteenable,
    output logic                wr_waitrequest,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int                RUN_W    = $clog2(MAX_RD_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_RD_RUN);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    arb_state_e        state;
    logic [RUN_W-1:0]  run_cnt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              rd_grant;
    logic              wr_grant;

    // A write only overtakes a read once the read streak has hit its limit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (reset_n && state == SERVE && !clr_start) begin
            if (rd_read && wr_write) begin
                if (run_cnt == RUN_MAX) wr_grant = 1'b1;
                else                    rd_grant = 1'b1;
            end else begin
                rd_grant = rd_read;
                wr_grant = wr_write;
            end
        end
    end

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = rd_address;
        mem_writedata  = wr_writedata;
        mem_byteenable = '1;
        if (reset_n) begin
            if (state == CLEAR) begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = clr_ptr;
                mem_writedata  = CLEAR_VALUE;
            end else if (wr_grant) begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = wr_address;
                mem_byteenable = wr_byteenable;
            end else if (rd_grant) begin
                mem_chipselect = 1'b1;
            end
        end
    end

    assign rd_waitrequest = !rd_grant;
    assign wr_waitrequest = !wr_grant;
    assign rd_readdata    = mem_readdata;
    assign clr_busy       = (state == CLEAR);
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= SERVE;
            run_cnt          <= '0;
            clr_ptr          <= '0;
            rd_readdatavalid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rd_readdatavalid <= rd_grant;

            // The streak only matters while a write is actually waiting.
            if (!wr_write || wr_grant)
                run_cnt <= '0;
            else if (rd_grant && run_cnt != RUN_MAX)
                run_cnt <= run_cnt + RUN_W'(1);

            case (state)
                SERVE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state   <= SERVE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: memory model, per-cycle reference model and directed scenarios.
module tb_vga_mem_arbiter;

    localparam int DEPTH   = 16;
    localparam int MAX_RUN = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_read = 1'b0;
    logic [15:0] rd_address = '0;
    logic        rd_waitrequest;
    logic [31:0] rd_readdata;
    logic        rd_readdatavalid;
    logic        wr_write = 1'b0;
    logic [15:0] wr_address = '0;
    logic [31:0] wr_writedata = '0;
    logic [3:0]  wr_byteenable = '0;
    logic        wr_waitrequest;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    int checks = 0;
    int failures = 0;

    vga_mem_arbiter #(
        .ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .MAX_RD_RUN(MAX_RUN), .CLEAR_VALUE(32'h0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_read(rd_read), .rd_address(rd_address), .rd_waitrequest(rd_waitrequest),
        .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
        .wr_write(wr_write), .wr_address(wr_address), .wr_writedata(wr_writedata),
        .wr_byteenable(wr_byteenable), .wr_waitrequest(wr_waitrequest),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [15:0] a;
        a = 16'(i);
        case (a)
            16'h0010: return 32'h1111_0010;
            16'h0011: return 32'h2222_0011;
            16'h0012: return 32'h3333_0012;
            16'h0100: return 32'h1234_5678;
            default:  return {~a, a};
        endcase
    endfunction

    // Single-port synchronous memory: read data appears the cycle after the read.
    logic [31:0] fake_mem [65536];
    initial begin
        for (int i = 0; i < 65536; i++) fake_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) fake_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else if (mem_chipselect) begin
                mem_readdata <= fake_mem[mem_address];
            end
        end
    end

    // Reference model: streak of reads against a waiting write, clear countdown, shadow memory.
    logic [31:0] ref_mem [65536];
    int          m_streak;
    int          m_clear_left;
    bit          m_exp_valid;
    logic [31:0] m_exp_data;
    bit          m_rg, m_wg;
    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        m_streak = 0; m_clear_left = 0; m_exp_valid = 0; m_exp_data = '0;
        forever begin
            @(negedge clk);
            check("m_clken", mem_clken, 1);
            if (!reset_n) begin
                check("m_rst_rd_wait", rd_waitrequest, 1);
                check("m_rst_wr_wait", wr_waitrequest, 1);
                check("m_rst_cs", mem_chipselect, 0);
                check("m_rst_we", mem_write, 0);
                check("m_rst_busy", clr_busy, 0);
                check("m_rst_valid", rd_readdatavalid, 0);
                m_streak = 0; m_clear_left = 0; m_exp_valid = 0;
            end else begin
                check("m_valid", rd_readdatavalid, m_exp_valid);
                if (m_exp_valid) check("m_rdata", rd_readdata, m_exp_data);
                check("m_busy", clr_busy, m_clear_left > 0);
                m_rg = 0; m_wg = 0;
                if (m_clear_left > 0) begin
                    check("m_clr_cs", mem_chipselect, 1);
                    check("m_clr_we", mem_write, 1);
                    check("m_clr_addr", mem_address, DEPTH - m_clear_left);
                    check("m_clr_data", mem_writedata, 0);
                    check("m_clr_be", mem_byteenable, 4'hF);
                    ref_mem[DEPTH - m_clear_left] = 32'h0;
                    m_clear_left--;
                end else if (clr_start) begin
                    check("m_start_cs", mem_chipselect, 0);
                    m_clear_left = DEPTH;
                end else begin
                    if (rd_read && wr_write) begin
                        if (m_streak >= MAX_RUN) m_wg = 1; else m_rg = 1;
                    end else begin
                        m_rg = rd_read; m_wg = wr_write;
                    end
                    check("m_cs", mem_chipselect, m_rg | m_wg);
                    if (m_wg) begin
                        check("m_wr_we", mem_write, 1);
                        check("m_wr_addr", mem_address, wr_address);
                        check("m_wr_data", mem_writedata, wr_writedata);
                        check("m_wr_be", mem_byteenable, wr_byteenable);
                        for (int b = 0; b < 4; b++)
                            if (wr_byteenable[b]) ref_mem[wr_address][8*b +: 8] = wr_writedata[8*b +: 8];
                    end
                    if (m_rg) begin
                        check("m_rd_we", mem_write, 0);
                        check("m_rd_addr", mem_address, rd_address);
                        check("m_rd_be", mem_byteenable, 4'hF);
                    end
                end
                check("m_rd_wait", rd_waitrequest, !m_rg);
                check("m_wr_wait", wr_waitrequest, !m_wg);
                if (!wr_write || m_wg) m_streak = 0;
                else if (m_rg && m_streak < MAX_RUN) m_streak++;
                m_exp_valid = m_rg;
                if (m_rg) m_exp_data = ref_mem[rd_address];
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        bit ok = 0;
        cycle();
        wr_write = 1; wr_address = a; wr_writedata = d; wr_byteenable = be;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!wr_waitrequest) begin ok = 1; break; end
            cycle();
        end
        check("wr_accept", ok, 1);
        cycle();
        wr_write = 0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input string name);
        bit ok = 0;
        cycle();
        rd_read = 1; rd_address = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rd_waitrequest) begin ok = 1; break; end
            cycle();
        end
        check("rd_accept", ok, 1);
        cycle();
        rd_read = 0;
        @(negedge clk);
        check({name, "_valid"}, rd_readdatavalid, 1);
        check(name, rd_readdata, exp);
    endtask

    logic [17:0] pattern;
    bit          rg, wg;
    int          busy_n;

    initial begin
        // Reset state
        #1;
        check("rst_rd_wait", rd_waitrequest, 1);
        check("rst_wr_wait", wr_waitrequest, 1);
        check("rst_busy", clr_busy, 0);
        check("rst_valid", rd_readdatavalid, 0);
        repeat (3) cycle();
        reset_n = 1;
        @(negedge clk);
        check("idle_cs", mem_chipselect, 0);

        // 1: back-to-back reads
        cycle(); rd_read = 1; rd_address = 16'h0010;
        @(negedge clk); check("t1_grant0", rd_waitrequest, 0);
        cycle(); rd_address = 16'h0011;
        @(negedge clk); check("t1_v0", rd_readdatavalid, 1); check("t1_d0", rd_readdata, 32'h1111_0010);
        cycle(); rd_address = 16'h0012;
        @(negedge clk); check("t1_v1", rd_readdatavalid, 1); check("t1_d1", rd_readdata, 32'h2222_0011);
        cycle(); rd_read = 0;
        @(negedge clk); check("t1_v2", rd_readdatavalid, 1); check("t1_d2", rd_readdata, 32'h3333_0012);
        cycle();
        @(negedge clk); check("t1_vend", rd_readdatavalid, 0);

        // 2: partial write then read; write immediately followed by read
        do_write(16'h0100, 32'hDEAD_BEEF, 4'b0011);
        do_read(16'h0100, 32'h1234_BEEF, "t2_merge");
        cycle(); wr_write = 1; wr_address = 16'h0200; wr_writedata = 32'h0BAD_F00D; wr_byteenable = 4'hF;
        @(negedge clk); check("t2_wgrant", wr_waitrequest, 0);
        cycle(); wr_write = 0; rd_read = 1; rd_address = 16'h0200;
        @(negedge clk); check("t2_rgrant", rd_waitrequest, 0);
        cycle(); rd_read = 0;
        @(negedge clk); check("t2_raw", rd_readdata, 32'h0BAD_F00D);

        // 3: both masters continuously -> 8 reads then 1 write, repeating
        cycle();
        rd_read = 1; rd_address = 16'h0400;
        wr_write = 1; wr_address = 16'h0500; wr_writedata = 32'h5000_0000; wr_byteenable = 4'hF;
        pattern = '0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rg = !rd_waitrequest; wg = !wr_waitrequest;
            check("t3_single", rg ^ wg, 1);
            pattern[i] = wg;
            cycle();
            if (rg) rd_address = rd_address + 16'd1;
            if (wg) begin wr_address = wr_address + 16'd1; wr_writedata = wr_writedata + 32'd1; end
        end
        rd_read = 0; wr_write = 0;
        check("t3_pattern", pattern, 18'h2_0100);

        // 4: clear sweep while both request
        cycle();
        rd_read = 1; rd_address = 16'h0030;
        wr_write = 1; wr_address = 16'h0031; wr_writedata = 32'h7777_0031; wr_byteenable = 4'hF;
        clr_start = 1;
        @(negedge clk);
        check("t4_start_rw", rd_waitrequest, 1);
        check("t4_start_ww", wr_waitrequest, 1);
        cycle(); clr_start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("t4_busy", clr_busy, 1);
            check("t4_rd_wait", rd_waitrequest, 1);
            check("t4_wr_wait", wr_waitrequest, 1);
            cycle();
        end
        @(negedge clk);
        check("t4_done", clr_busy, 0);
        check("t4_rd_served", rd_waitrequest, 0);
        cycle(); rd_read = 0;
        @(negedge clk); check("t4_wr_served", wr_waitrequest, 0);
        cycle(); wr_write = 0;
        for (int i = 0; i < DEPTH; i++) do_read(16'(i), 32'h0, "t4_zero");

        // 5: reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) do_write(16'(i), 32'hCAFE_0000 | i, 4'hF);
        cycle(); clr_start = 1;
        cycle(); clr_start = 0;
        repeat (5) cycle();
        check("t5_ptr5", mem_address, 16'h0005);
        reset_n = 0;
        #1;
        check("t5_busy", clr_busy, 0);
        check("t5_cs", mem_chipselect, 0);
        check("t5_rd_wait", rd_waitrequest, 1);
        check("t5_wr_wait", wr_waitrequest, 1);
        cycle();
        reset_n = 1;
        do_read(16'h0004, 32'h0, "t5_w4");
        do_read(16'h0005, 32'hCAFE_0005, "t5_w5");
        do_read(16'h000F, 32'hCAFE_000F, "t5_w15");

        // 6: second clr_start mid-sweep does not stretch the sweep
        cycle(); clr_start = 1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clr_busy) busy_n++;
            cycle();
            clr_start = (i == 6);
        end
        clr_start = 0;
        check("t6_len", busy_n, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
